move_sequencer: RTL and testbench
=================================

# move_sequencer

Central game controller for the tic-tac-toe chip. Sequences every move into the board state registers: accepts human moves from the input pins and AI moves from the AI logic, validates them, drives the single board write port, and samples the win checker after each write. Owns turn order, move count, game-over/draw detection and the error flag. Sits between the input pins, the AI logic, the board registers and the win checker.

## Interface
- AI_TIMEOUT, 15: cycles to wait for `ai_valid` before the fallback move is used (1..255).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ai_en  in  1  1 = O is played by the AI
- h_valid  in  1  human move request
- h_ready  out  1  human move can be accepted this cycle
- h_piece  in  2  01 = X, 10 = O (00/11 are illegal)
- h_row, h_col  in  2 each  0..2 (3 is illegal)
- ai_start  out  1  one-cycle pulse requesting an AI move
- ai_valid  in  1  AI move available
- ai_ready  out  1  AI move can be accepted
- ai_row, ai_col  in  2 each  AI move coordinates
- board  in  18  current board; cell i = row*3+col occupies bits [2i+1:2i]
- win_in  in  2  win checker result: 00 none, 01 X, 10 O
- board_we  out  1  write strobe
- board_addr  out  4  cell index 0..8
- board_data  out  2  piece written
- turn  out  2  piece whose move is expected (01/10), 00 when game over
- win  out  2  00 playing, 01 X won, 10 O won, 11 draw
- err  out  1  last request was rejected

## Operation
- States: X_TURN, O_TURN, AI_START, AI_WAIT, WRITE, CHECK, DONE.
- X_TURN / O_TURN: `h_ready` = 1. On `h_valid`, validate: piece matches turn, row < 3, col < 3, target cell 00. Valid -> latch addr/piece, clear `err`, go to WRITE. Invalid -> set `err`, stay in the state.
- O moves offered by a human while `ai_en` = 1 are rejected with `err` in X_TURN (wrong piece); no human O is accepted.
- AI_START: `ai_start` = 1 for exactly one cycle, timeout counter loaded with 0, go to AI_WAIT.
- AI_WAIT: `ai_ready` = 1. Valid AI move (same checks, piece O) -> WRITE. Invalid AI move -> set `err`, return to AI_START (re-request). Counter reaching AI_TIMEOUT -> fallback: write O into the lowest-index empty cell, go to WRITE.
- WRITE: `board_we` = 1 for one cycle with the latched addr/data. Move count increments (0..9, saturating).
- CHECK: sample `win_in`. 01/10 -> `win` = that value, go to DONE. Else if the move count is 9 -> `win` = 11, go to DONE. Else go to the next turn: after X, go to AI_START if `ai_en` else O_TURN; after O, go to X_TURN. `ai_en` is sampled only here.
- DONE: `h_ready`, `ai_ready` = 0, `turn` = 00. Any `h_valid` sets `err`. Leave only via reset.
- Reset (any state, including mid-WRITE or AI_WAIT): state X_TURN, `turn` = 01, `win` = 00, `err` = 0, count 0, `board_we` = 0, `ai_start` = 0. The board registers reset on the same reset.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `h_valid`/`ai_valid` to outputs.
- A move accepted in cycle N (valid & ready): `board_we` in N+1, `win_in` sampled in N+2, next turn state / DONE in N+3. `h_ready` is low for N+1..N+2.
- `err` is updated in the cycle after the rejected request and is held until the next accepted move or reset.
- AI latency: `ai_start` in cycle M. A move presented in M+1..M+AI_TIMEOUT is accepted. If none arrives, the fallback write happens at M+AI_TIMEOUT+1.
- `ai_valid` asserted outside AI_WAIT is ignored. It does not set `err`.

## Structure
- Shared package `ttt_pkg`: cell encodings (EMPTY 00, X 01, O 10), win codes (NONE, XWIN, OWIN, DRAW), the state enum, and the cell-index helper row*3+col. The output controller and win checker import the same encodings.
- Sub-module `first_empty_cell`: combinational priority encoder over `board`; outputs index 0..8 plus an `any_empty` flag.

## Test plan
- Reset, `ai_en`=0, X at (0,0) -> `board_we` at N+1 with addr 0, data 01; `turn` = 10 at N+3.
- X already at (1,1); O requests (1,1) -> `err`=1, no `board_we`, `turn` stays 10. O then requests (2,2) -> accepted, `err`=0.
- Row = 3 or piece = 11 in X_TURN -> `err`=1, state unchanged.
- X plays 0,4,8 with O between; `win_in`=01 after the third X -> `win`=01, `turn`=00, later `h_valid` sets `err`.
- `ai_en`=1, X plays cell 0, AI never responds -> one `ai_start` pulse, fallback writes addr 1 data 10 at AI_TIMEOUT+1 cycles after the pulse.
- Nine legal moves with `win_in`=00 -> `win`=11 after the ninth CHECK. Reset asserted during AI_WAIT -> X_TURN next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: cell and win encodings, controller states and cell indexing shared across the tic-tac-toe chip
package ttt_pkg;
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_X      = 2'b01;
    localparam logic [1:0] WIN_O      = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;
    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {X_TURN, O_TURN, AI_START, AI_WAIT, WRITE, CHECK, DONE} state_e;

    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return {2'b00, row} * 4'd3 + {2'b00, col};
    endfunction
endpackage

// File: rtl/first_empty_cell.sv
// first_empty_cell: priority encoder returning the lowest-index empty board cell
module first_empty_cell
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic [3:0]  idx,
    output logic        any_empty
);
    always_comb begin
        idx = 4'd0;
        any_empty = 1'b0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (board[2*i +: 2] == CELL_EMPTY) begin
                idx = 4'(i);
                any_empty = 1'b1;
            end
        end
    end
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: validates human/AI moves, drives the board write port and tracks turn, win and error
module move_sequencer
    import ttt_pkg::*;
#(
    parameter int AI_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ai_en,
    input  logic        h_valid,
    output logic        h_ready,
    input  logic [1:0]  h_piece,
    input  logic [1:0]  h_row,
    input  logic [1:0]  h_col,
    output logic        ai_start,
    input  logic        ai_valid,
    output logic        ai_ready,
    input  logic [1:0]  ai_row,
    input  logic [1:0]  ai_col,
    input  logic [17:0] board,
    input  logic [1:0]  win_in,
    output logic        board_we,
    output logic [3:0]  board_addr,
    output logic [1:0]  board_data,
    output logic [1:0]  turn,
    output logic [1:0]  win,
    output logic        err
);
    localparam logic [7:0] TMO_LAST = 8'(AI_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  addr_q, addr_d, count_q, count_d, fe_idx, req_idx;
    logic [1:0]  piece_q, piece_d, win_q, win_d;
    logic [1:0]  exp_piece, req_piece, req_row, req_col;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d, any_empty, req_ok;

    first_empty_cell u_first_empty (.board(board), .idx(fe_idx), .any_empty(any_empty));

    // Human and AI requests share one validator; the AI always plays O
    assign exp_piece = (state_q == X_TURN) ? CELL_X : CELL_O;
    assign req_piece = (state_q == AI_WAIT) ? CELL_O : h_piece;
    assign req_row   = (state_q == AI_WAIT) ? ai_row : h_row;
    assign req_col   = (state_q == AI_WAIT) ? ai_col : h_col;
    assign req_idx   = cell_idx(req_row, req_col);
    assign req_ok    = req_piece == exp_piece && req_row < 2'd3 && req_col < 2'd3 &&
                       board[{req_idx, 1'b0} +: 2] == CELL_EMPTY;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        piece_d = piece_q;
        win_d   = win_q;
        err_d   = err_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        case (state_q)
            X_TURN, O_TURN: begin
                if (h_valid && req_ok) begin
                    addr_d  = req_idx;
                    piece_d = exp_piece;
                    err_d   = 1'b0;
                    state_d = WRITE;
                end else if (h_valid) begin
                    err_d = 1'b1;
                end
            end
            AI_START: begin
                tmo_d   = 8'd0;
                state_d = AI_WAIT;
            end
            AI_WAIT: begin
                if (ai_valid && req_ok) begin
                    addr_d  = req_idx;
                    piece_d = CELL_O;
                    err_d   = 1'b0;
                    state_d = WRITE;
                end else if (ai_valid) begin
                    err_d   = 1'b1;
                    state_d = AI_START;
                end else if (tmo_q == TMO_LAST && any_empty) begin
                    addr_d  = fe_idx;
                    piece_d = CELL_O;
                    err_d   = 1'b0;
                    state_d = WRITE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WRITE: begin
                count_d = (count_q == 4'd9) ? count_q : count_q + 4'd1;
                state_d = CHECK;
            end
            CHECK: begin
                if (win_in == WIN_X || win_in == WIN_O) begin
                    win_d   = win_in;
                    state_d = DONE;
                end else if (count_q == 4'd9) begin
                    win_d   = WIN_DRAW;
                    state_d = DONE;
                end else begin
                    state_d = (piece_q == CELL_X) ? (ai_en ? AI_START : O_TURN) : X_TURN;
                end
            end
            DONE: err_d = h_valid ? 1'b1 : err_q;
            default: state_d = X_TURN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= X_TURN;
            addr_q  <= 4'd0;
            piece_q <= CELL_EMPTY;
            win_q   <= WIN_NONE;
            err_q   <= 1'b0;
            count_q <= 4'd0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            piece_q <= piece_d;
            win_q   <= win_d;
            err_q   <= err_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
        end
    end

    assign h_ready    = state_q == X_TURN || state_q == O_TURN;
    assign ai_start   = state_q == AI_START;
    assign ai_ready   = state_q == AI_WAIT;
    assign board_we   = state_q == WRITE;
    assign board_addr = addr_q;
    assign board_data = piece_q;
    assign win        = win_q;
    assign err        = err_q;
    // While a move is in flight, turn still shows the piece being written
    assign turn = (state_q == X_TURN) ? CELL_X :
                  (state_q == O_TURN || state_q == AI_START || state_q == AI_WAIT) ? CELL_O :
                  (state_q == DONE) ? CELL_EMPTY : piece_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: table, directed and random game checks against a game-level reference model
module tb_move_sequencer;
    localparam int T = 15;

    logic        clk = 1'b0, reset = 1'b0, ai_en = 1'b0, h_valid = 1'b0, ai_valid = 1'b0;
    logic [1:0]  h_piece = 2'b00, h_row = 2'b00, h_col = 2'b00, ai_row = 2'b00, ai_col = 2'b00;
    logic [1:0]  win_in;
    logic [17:0] board;
    logic        h_ready, ai_start, ai_ready, board_we, err;
    logic [3:0]  board_addr;
    logic [1:0]  board_data, turn, win;
    logic        force_none = 1'b0;
    logic [1:0]  bc [9];

    int checks = 0, failures = 0;
    logic [1:0] mb [9];
    logic [1:0] m_turn, m_win;
    int  m_count;
    bit  m_err, err_known, m_ai;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    typedef struct {
        logic [1:0] p, r, c;
        bit         acc;
        logic [3:0] addr;
        logic [1:0] turn;
        bit         err;
    } vec_t;

    always #5 clk = ~clk;

    move_sequencer #(.AI_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .ai_en(ai_en), .h_valid(h_valid), .h_ready(h_ready),
        .h_piece(h_piece), .h_row(h_row), .h_col(h_col), .ai_start(ai_start),
        .ai_valid(ai_valid), .ai_ready(ai_ready), .ai_row(ai_row), .ai_col(ai_col),
        .board(board), .win_in(win_in), .board_we(board_we), .board_addr(board_addr),
        .board_data(board_data), .turn(turn), .win(win), .err(err)
    );

    // Board registers and win checker surrounding the controller
    always_ff @(posedge clk)
        if (reset) board <= '0;
        else if (board_we) board[{board_addr, 1'b0} +: 2] <= board_data;

    function automatic logic [1:0] winner(input logic [1:0] c [9]);
        winner = 2'b00;
        for (int k = 0; k < 8; k++)
            if (c[lines[k][0]] != 2'b00 && c[lines[k][0]] == c[lines[k][1]] && c[lines[k][1]] == c[lines[k][2]])
                winner = c[lines[k][0]];
    endfunction

    always_comb begin
        for (int i = 0; i < 9; i++) bc[i] = board[2*i +: 2];
        win_in = force_none ? 2'b00 : winner(bc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; h_valid = 1'b0; ai_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) mb[i] = 2'b00;
        m_turn = 2'b01; m_win = 2'b00; m_count = 0; m_err = 1'b0; err_known = 1'b1;
    endtask

    task automatic apply_model(input int idx, input logic [1:0] p);
        logic [1:0] w;
        mb[idx] = p;
        m_count++;
        m_err = 1'b0;
        err_known = 1'b1;
        w = winner(mb);
        m_win = (w != 2'b00) ? w : (m_count == 9) ? 2'b11 : 2'b00;
        m_turn = (m_win != 2'b00) ? 2'b00 : (p == 2'b01) ? 2'b10 : 2'b01;
    endtask

    task automatic post_move_checks();
        chk("turn", turn, m_turn);
        chk("win", win, m_win);
        if (err_known) chk("err", err, m_err);
        chk("ai_start", ai_start, m_win == 2'b00 && m_ai && m_turn == 2'b10);
    endtask

    task automatic human(input logic [1:0] p, input logic [1:0] r, input logic [1:0] c);
        int idx;
        bit ok;
        idx = int'(r) * 3 + int'(c);
        ok = m_win == 2'b00 && p == m_turn && r < 2'd3 && c < 2'd3 && mb[idx] == 2'b00;
        chk("h_ready", h_ready, m_win == 2'b00);
        h_valid = 1'b1; h_piece = p; h_row = r; h_col = c;
        @(negedge clk);
        h_valid = 1'b0;
        if (!ok) begin
            m_err = 1'b1; err_known = 1'b1;
            chk("rej_we", board_we, 0);
            chk("rej_err", err, 1);
            chk("rej_turn", turn, m_turn);
            return;
        end
        chk("we", board_we, 1);
        chk("addr", board_addr, idx);
        chk("data", board_data, p);
        chk("ready_n1", h_ready, 0);
        apply_model(idx, p);
        @(negedge clk);
        chk("ready_n2", h_ready, 0);
        chk("we_n2", board_we, 0);
        @(negedge clk);
        post_move_checks();
    endtask

    // Entered at the negedge of the ai_start cycle; d is the response delay, d > T means no response
    task automatic ai_move(input int d, input logic [1:0] r, input logic [1:0] c);
        int idx;
        bit ok;
        if (d <= T) begin
            repeat (d) @(negedge clk);
            chk("ai_ready", ai_ready, 1);
            chk("ai_start_low", ai_start, 0);
            ai_valid = 1'b1; ai_row = r; ai_col = c;
            @(negedge clk);
            ai_valid = 1'b0;
            idx = int'(r) * 3 + int'(c);
            ok = r < 2'd3 && c < 2'd3 && mb[idx] == 2'b00;
            if (!ok) begin
                m_err = 1'b1; err_known = 1'b1;
                chk("ai_rej_err", err, 1);
                chk("ai_rej_we", board_we, 0);
                chk("ai_restart", ai_start, 1);
                return;
            end
        end else begin
            repeat (T + 1) @(negedge clk);
            idx = 0;
            for (int i = 8; i >= 0; i--) if (mb[i] == 2'b00) idx = i;
        end
        chk("ai_we", board_we, 1);
        chk("ai_addr", board_addr, idx);
        chk("ai_data", board_data, 2'b10);
        apply_model(idx, 2'b10);
        if (d > T) err_known = 1'b0;
        repeat (2) @(negedge clk);
        post_move_checks();
    endtask

    task automatic apply_vec(input vec_t v);
        h_valid = 1'b1; h_piece = v.p; h_row = v.r; h_col = v.c;
        @(negedge clk);
        h_valid = 1'b0;
        chk("tbl_we", board_we, v.acc);
        if (v.acc) begin
            chk("tbl_addr", board_addr, v.addr);
            chk("tbl_data", board_data, v.p);
            repeat (2) @(negedge clk);
        end
        chk("tbl_turn", turn, v.turn);
        chk("tbl_err", err, v.err);
    endtask

    initial begin
        vec_t vt [14];
        int pulses, we_cnt, d, idx;
        logic [1:0] p, r, c;
        int empties [$];

        vt = '{
            '{2'd1, 2'd0, 2'd0, 1'b1, 4'd0, 2'b10, 1'b0},
            '{2'd1, 2'd1, 2'd1, 1'b0, 4'd0, 2'b10, 1'b1},
            '{2'd2, 2'd0, 2'd0, 1'b0, 4'd0, 2'b10, 1'b1},
            '{2'd2, 2'd2, 2'd2, 1'b1, 4'd8, 2'b01, 1'b0},
            '{2'd1, 2'd3, 2'd0, 1'b0, 4'd0, 2'b01, 1'b1},
            '{2'd3, 2'd1, 2'd0, 1'b0, 4'd0, 2'b01, 1'b1},
            '{2'd1, 2'd1, 2'd1, 1'b1, 4'd4, 2'b10, 1'b0},
            '{2'd2, 2'd1, 2'd1, 1'b0, 4'd0, 2'b10, 1'b1},
            '{2'd2, 2'd0, 2'd3, 1'b0, 4'd0, 2'b10, 1'b1},
            '{2'd2, 2'd2, 2'd0, 1'b1, 4'd6, 2'b01, 1'b0},
            '{2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 2'b01, 1'b1},
            '{2'd1, 2'd0, 2'd1, 1'b1, 4'd1, 2'b10, 1'b0},
            '{2'd2, 2'd2, 2'd1, 1'b1, 4'd7, 2'b00, 1'b0},
            '{2'd1, 2'd0, 2'd2, 1'b0, 4'd0, 2'b00, 1'b1}
        };

        m_ai = 1'b0;
        do_reset();
        chk("rst_turn", turn, 2'b01);
        chk("rst_win", win, 2'b00);
        chk("rst_err", err, 0);
        chk("rst_we", board_we, 0);
        chk("rst_ai_start", ai_start, 0);
        chk("rst_h_ready", h_ready, 1);
        chk("rst_ai_ready", ai_ready, 0);

        foreach (vt[i]) apply_vec(vt[i]);
        chk("tbl_owin", win, 2'b10);

        // AI handshake outside AI_WAIT must be ignored
        do_reset();
        ai_valid = 1'b1; ai_row = 2'd0; ai_col = 2'd0;
        @(negedge clk);
        ai_valid = 1'b0;
        chk("stray_ai_we", board_we, 0);
        chk("stray_ai_err", err, 0);
        chk("stray_ai_turn", turn, 2'b01);

        // X takes the 0-4-8 diagonal
        do_reset();
        human(2'd1, 2'd0, 2'd0);
        human(2'd2, 2'd0, 2'd1);
        human(2'd1, 2'd1, 2'd1);
        human(2'd2, 2'd0, 2'd2);
        human(2'd1, 2'd2, 2'd2);
        chk("xwin_win", win, 2'b01);
        chk("xwin_turn", turn, 2'b00);
        human(2'd1, 2'd1, 2'd0);
        chk("xwin_err", err, 1);

        // Silent AI: single ai_start pulse, fallback O into cell 1 at M+T+1
        m_ai = 1'b1; ai_en = 1'b1;
        do_reset();
        human(2'd1, 2'd0, 2'd0);
        pulses = 0; we_cnt = 0;
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            pulses += int'(ai_start);
            we_cnt += int'(board_we);
        end
        @(negedge clk);
        chk("tmo_extra_pulses", pulses, 0);
        chk("tmo_early_we", we_cnt, 0);
        chk("tmo_we", board_we, 1);
        chk("tmo_addr", board_addr, 4'd1);
        chk("tmo_data", board_data, 2'b10);

        // Reset while waiting on the AI after an AI error
        do_reset();
        human(2'd1, 2'd0, 2'd0);
        ai_move(2, 2'd0, 2'd0);
        repeat (3) @(negedge clk);
        chk("midwait_ai_ready", ai_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_turn", turn, 2'b01);
        chk("midrst_win", win, 2'b00);
        chk("midrst_err", err, 0);
        chk("midrst_we", board_we, 0);
        chk("midrst_ai_start", ai_start, 0);
        chk("midrst_ai_ready", ai_ready, 0);
        chk("midrst_h_ready", h_ready, 1);
        ai_en = 1'b0; m_ai = 1'b0;

        // Nine moves with the win checker held at none
        do_reset();
        force_none = 1'b1;
        for (int i = 0; i < 9; i++) begin
            h_valid = 1'b1; h_piece = (i % 2 == 1) ? 2'b10 : 2'b01; h_row = 2'(i / 3); h_col = 2'(i % 3);
            @(negedge clk);
            h_valid = 1'b0;
            chk("draw_we", board_we, 1);
            repeat (2) @(negedge clk);
            if (i < 8) chk("draw_turn", turn, (i % 2 == 1) ? 2'b01 : 2'b10);
            if (i == 7) chk("draw_win_pre", win, 2'b00);
        end
        chk("draw_win", win, 2'b11);
        chk("draw_turn_done", turn, 2'b00);
        force_none = 1'b0;

        // Random games against the reference model
        for (int g = 0; g < 25; g++) begin
            m_ai = 1'($urandom % 2);
            ai_en = m_ai;
            do_reset();
            for (int s = 0; s < 60 && m_win == 2'b00; s++) begin
                if (m_ai && m_turn == 2'b10) begin
                    d = $urandom_range(1, T + 3);
                    empties.delete();
                    for (int i = 0; i < 9; i++) if (mb[i] == 2'b00) empties.push_back(i);
                    if ($urandom % 4 != 0) begin
                        idx = empties[$urandom % empties.size()];
                        r = 2'(idx / 3); c = 2'(idx % 3);
                    end else begin
                        r = 2'($urandom % 4); c = 2'($urandom % 4);
                    end
                    ai_move(d, r, c);
                end else begin
                    p = ($urandom % 4 != 0) ? m_turn : 2'($urandom % 4);
                    r = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
                    c = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
                    human(p, r, c);
                end
            end
            if (m_win != 2'b00) human(2'($urandom % 4), 2'($urandom % 3), 2'($urandom % 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
